// File: rtl/window_accum.sv
// window_accum: sums exactly WINDOW consecutive unsigned samples into a DSIZE-bit result and
// presents each result on a valid/ready output. The output register acts as a one-deep
// buffer: a new partial window keeps filling while a finished sum waits for the consumer.
// Only the final sample of a window stalls, and only when the previous sum is still held.
//
// Ports:
//   clock      rising-edge clock
//   rst        synchronous, active-high reset
//   clear      (only with WINDOW_ACCUM_CLEAR_EN) synchronous discard of the partial window
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle
//   in_data    unsigned sample, ISIZE bits
//   out_valid  out_data holds a completed window sum
//   out_ready  consumer accepts out_data this cycle
//   out_data   window sum, zero-extended, DSIZE bits
//   fill       samples accumulated in the current partial window
//
// Optional feature macro: WINDOW_ACCUM_CLEAR_EN adds the clear input.
module window_accum #(
  parameter int unsigned ISIZE  = 8,
  parameter int unsigned WINDOW = 256,
  parameter int unsigned DSIZE  = 16,
  localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
  input  logic             clock,
  input  logic             rst,
`ifdef WINDOW_ACCUM_CLEAR_EN
  input  logic             clear,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ISIZE-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic [CNT_W-1:0] fill
);

  // Elaboration-time parameter checks.
  if (WINDOW < 1 || WINDOW > 65536) begin : gen_bad_window
    $error("window_accum: WINDOW must be in 1..65536");
  end
  if (DSIZE < ISIZE + CNT_W) begin : gen_bad_dsize
    $error("window_accum: DSIZE must be >= ISIZE + CNT_W");
  end

  localparam logic [CNT_W-1:0] LastFill = CNT_W'(WINDOW - 1);

  logic             clear_req;
`ifdef WINDOW_ACCUM_CLEAR_EN
  assign clear_req = clear;
`else
  assign clear_req = 1'b0;
`endif

  logic [DSIZE-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             out_valid_q, out_valid_d;
  logic [DSIZE-1:0] out_data_q, out_data_d;

  logic             last;
  logic             in_fire;
  logic             out_fire;
  logic [DSIZE-1:0] sample_ext;
  logic [DSIZE-1:0] sum;

  assign last = (fill_q == LastFill);

  // Combinational from out_ready: the closing sample may pass in the same cycle the held
  // result drains.
  assign in_ready = ~rst & ~clear_req & ~(last & out_valid_q & ~out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  // Gate the sample so an X on in_data while idle never reaches the accumulator.
  assign sample_ext = in_fire ? DSIZE'(in_data) : '0;
  assign sum        = acc_q + sample_ext;

  always_comb begin
    acc_d       = acc_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (clear_req) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (in_fire) begin
      if (last) begin
        // A completing window overrides a same-cycle drain.
        out_data_d  = sum;
        out_valid_d = 1'b1;
        acc_d       = '0;
        fill_d      = '0;
      end else begin
        acc_d  = sum;
        fill_d = fill_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      acc_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_window_accum.sv
// Directed testbench for window_accum with ISIZE=8, WINDOW=4, DSIZE=10.
// Inputs change 1 time unit after each rising edge; outputs are checked one further unit later.
module tb_window_accum;

  localparam int unsigned ISIZE  = 8;
  localparam int unsigned WINDOW = 4;
  localparam int unsigned DSIZE  = 10;
  localparam int unsigned CNT_W  = 2;

  logic             clock;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [ISIZE-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] out_data;
  logic [CNT_W-1:0] fill;
`ifdef WINDOW_ACCUM_CLEAR_EN
  logic             clear;
`endif

  int checks = 0;
  int errors = 0;

  window_accum #(
    .ISIZE (ISIZE),
    .WINDOW(WINDOW),
    .DSIZE (DSIZE)
  ) dut (
    .clock    (clock),
    .rst      (rst),
`ifdef WINDOW_ACCUM_CLEAR_EN
    .clear    (clear),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .fill     (fill)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one sample, require it to be accepted, then go idle.
  task automatic send(input logic [7:0] v, input string tag);
    in_valid = 1'b1;
    in_data  = v;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  logic [7:0] basic_v[4];
  logic [7:0] bp_v[3];

  initial begin
    basic_v = '{8'd10, 8'd20, 8'd30, 8'd40};
    bp_v    = '{8'd5, 8'd6, 8'd7};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b0;
`ifdef WINDOW_ACCUM_CLEAR_EN
    clear     = 1'b0;
`endif

    // Reset
    #1;
    check("rst_in_ready_t0", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic window, fill 0,1,2,3 then 0
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("basic_fill", 32'(fill), 32'(i));
      check("basic_no_valid", 32'(out_valid), 32'd0);
      send(basic_v[i], "basic");
    end
    check("basic_fill_wrap", 32'(fill), 32'd0);
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_out_data", 32'(out_data), 32'd100);
    tick();
    check("basic_valid_one_cycle", 32'(out_valid), 32'd0);

    // Max values
    for (int i = 0; i < 4; i++) send(8'd255, "max");
    check("max_out_valid", 32'(out_valid), 32'd1);
    check("max_out_data", 32'(out_data), 32'd1020);
    tick();
    check("max_drained", 32'(out_valid), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    send(8'd1, "bp");
    send(8'd2, "bp");
    send(8'd3, "bp");
    send(8'd4, "bp");
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data", 32'(out_data), 32'd10);
    for (int i = 0; i < 3; i++) send(bp_v[i], "bp_mid");
    check("bp_fill3", 32'(fill), 32'd3);
    check("bp_held_data", 32'(out_data), 32'd10);
    in_valid = 1'b1;
    in_data  = 8'd8;
    #1;
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    tick();
    check("bp_stall_fill", 32'(fill), 32'd3);
    check("bp_stall_data", 32'(out_data), 32'd10);
    check("bp_stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    check("bp_new_valid", 32'(out_valid), 32'd1);
    check("bp_new_data", 32'(out_data), 32'd26);
    check("bp_new_fill", 32'(fill), 32'd0);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Gaps then mid-window reset
    send(8'd5, "gap");
    tick();
    tick();
    tick();
    check("gap_fill1", 32'(fill), 32'd1);
    send(8'd5, "gap");
    check("gap_fill2", 32'(fill), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_fill", 32'(fill), 32'd0);
    for (int i = 0; i < 4; i++) send(8'd1, "midrst");
    check("midrst_out_valid", 32'(out_valid), 32'd1);
    check("midrst_out_data", 32'(out_data), 32'd4);
    tick();

`ifdef WINDOW_ACCUM_CLEAR_EN
    // Clear discards the partial window
    send(8'd9, "clr");
    send(8'd9, "clr");
    in_valid = 1'b1;
    in_data  = 8'd9;
    clear    = 1'b1;
    #1;
    check("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = 'x;
    check("clr_fill", 32'(fill), 32'd0);
    for (int i = 0; i < 4; i++) send(8'd2, "clr_after");
    check("clr_out_valid", 32'(out_valid), 32'd1);
    check("clr_out_data", 32'(out_data), 32'd8);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
